// File: rtl/ram_rd_check.sv
// Read-back checker for the 256 x 8 test RAM: walks addresses 0..255 at a paced rate,
// expects data == address, and reports error count, first failing address and pass/fail.
//
// state | meaning
// IDLE  | waiting for start; results of the last run are held
// PACE  | pacing delay of PACE_MAX+1 cycles before each read
// ISSUE | one-cycle read strobe for rd_addr
// WAIT  | RAM latency beyond the first cycle (RD_LAT-1 cycles)
// CHECK | compare returned word with the address, advance or finish
// DONE  | one-cycle completion pulse with pass result

module ram_rd_check #(
  parameter int RD_LAT   = 1,
  parameter int PACE_MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_flag,
  output logic [8:0] err_cnt,
  output logic [7:0] first_err_addr
);

  localparam int PACE_W = (PACE_MAX > 0) ? $clog2(PACE_MAX + 1) : 1;
  localparam logic [PACE_W-1:0] PACE_TC = PACE_W'(PACE_MAX);
  localparam logic [1:0] WAIT_LOAD = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PACE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t state;
  logic [PACE_W-1:0] pace_cnt;
  logic [1:0] wait_cnt;
  logic mismatch;

  assign mismatch = (rd_data != rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pace_cnt       <= '0;
      wait_cnt       <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      // abort leaves partial error results visible but never reports pass
      if (abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        pace_cnt <= '0;
        wait_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state          <= ST_PACE;
              busy           <= 1'b1;
              pace_cnt       <= '0;
              rd_addr        <= '0;
              err_cnt        <= '0;
              err_flag       <= 1'b0;
              first_err_addr <= '0;
              pass           <= 1'b0;
            end
          end
          ST_PACE: begin
            if (pace_cnt == PACE_TC) begin
              pace_cnt <= '0;
              state    <= ST_ISSUE;
              rd_en    <= 1'b1;
            end else begin
              pace_cnt <= pace_cnt + 1'b1;
            end
          end
          ST_ISSUE: begin
            if (RD_LAT > 1) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_CHECK;
            end
          end
          ST_WAIT: begin
            if (wait_cnt == 2'd0) state <= ST_CHECK;
            else wait_cnt <= wait_cnt - 1'b1;
          end
          ST_CHECK: begin
            if (mismatch) begin
              err_cnt <= err_cnt + 9'd1;
              if (!err_flag) begin
                first_err_addr <= rd_addr;
                err_flag       <= 1'b1;
              end
            end
            // address 255 is terminal, so rd_addr never wraps
            if (rd_addr == 8'hFF) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !(err_flag || mismatch);
            end else begin
              rd_addr <= rd_addr + 8'd1;
              state   <= ST_PACE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ram_rd_check.md
# ram_rd_check

Read-back checker for the 256-entry, 8-bit test RAM. After a start pulse it walks addresses 0 to 255 at a paced rate and issues one read per address. It compares each returned word against the pattern the write side stores, which is data equal to address. It accumulates an error count and the first failing address, then reports pass/fail with a one-cycle done pulse. It sits between the key/control logic and the RAM read port, alongside the write controller.

## Interface
- `RD_LAT`, default 1: RAM read latency in cycles from the `rd_en` cycle to valid `rd_data`; legal values are 1 to 4.
- `PACE_MAX`, default 9: the idle pacing counter runs 0..`PACE_MAX` before each read. Use 9 for simulation and 9_999_999 (0.2 s at 50 MHz) on the board.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level or pulse; sampled only in IDLE.
- `abort`  in  1  stops the run; has priority over `start`.
- `rd_data`  in  8  RAM read data.
- `rd_en`  out  1  one-cycle read strobe.
- `rd_addr`  out  8  read address; valid while `rd_en`=1.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of a complete run.
- `pass`  out  1  1 when the last complete run had zero errors.
- `err_flag`  out  1  at least one mismatch seen in the current or last run.
- `err_cnt`  out  9  mismatch count, range 0..256.
- `first_err_addr`  out  8  address of the first mismatch.

Reset is asynchronous and active-low on `rst_n`. Everything runs in the single `clk` domain. All outputs are registered.

## Operation
- FSM states: IDLE, PACE, ISSUE, WAIT, CHECK, DONE.
- IDLE
  - `start`=1 and `abort`=0 moves to PACE.
  - On that same edge: clear `rd_addr`, `err_cnt`, `err_flag`, `first_err_addr` and `pass`.
- PACE
  - Pace counter counts 0..`PACE_MAX`.
  - At `PACE_MAX` the counter clears and the FSM moves to ISSUE.
- ISSUE
  - `rd_en`=1 for exactly this cycle.
  - Next state is WAIT if `RD_LAT`>1, otherwise CHECK.
- WAIT: holds for `RD_LAT`-1 cycles, then moves to CHECK.
- CHECK
  - Samples `rd_data` and compares it with `rd_addr`.
  - On mismatch: `err_cnt`+1. If `err_flag` was 0, also load `first_err_addr`=`rd_addr` and set `err_flag`.
  - If `rd_addr`=255, move to DONE. Otherwise increment `rd_addr` and return to PACE.
- DONE
  - `done`=1 and `pass`=(`err_cnt`==0 after the final compare).
  - Returns to IDLE next cycle.
- `busy`=1 in PACE, ISSUE, WAIT and CHECK; 0 in IDLE and DONE.
- `abort` in any non-IDLE state:
  - Next state is IDLE and no `done` is produced.
  - `pass` stays 0.
  - `err_cnt`, `err_flag` and `first_err_addr` hold their partial values.
- `start` outside IDLE is ignored; there is no queued restart.
- `rd_addr` never wraps. 255 is terminal, and the 256 compares cannot overflow the 9-bit `err_cnt`.
- Results (`pass`, `err_*`) hold in IDLE until the next accepted start.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pace counter 0.
- Reset asserted mid-run: everything clears immediately, with no `done`.
- Per-address period is (`PACE_MAX`+1) + (`RD_LAT`+1) cycles, which is 12 at the defaults.
- Sequence with `start` sampled at edge 0 and defaults:
  - PACE occupies cycles 1..10.
  - ISSUE is cycle 11, with `rd_addr`=0.
  - CHECK is cycle 12.
  - The last CHECK is cycle 3072.
  - `done` is high in cycle 3073.
  - `busy` is low from cycle 3073.
- `abort` sampled at edge n: `busy`=0 and `rd_en`=0 from cycle n+1.

## Test plan
- Fault-free RAM model (data=addr, `RD_LAT`=1), `start` pulse: 256 `rd_en` strobes 12 cycles apart, `done` at cycle 3073, `pass`=1, `err_cnt`=0, `err_flag`=0.
- Model returns 0x00 at address 0x37: `err_cnt`=1, `first_err_addr`=0x37, `err_flag`=1, `pass`=0.
- Corrupt addresses 0x10 and 0xF0, then a second clean run: first run gives `err_cnt`=2 and `first_err_addr`=0x10; second run clears results at start and ends with `pass`=1.
- `abort` at cycle 500: `busy`=0 and no further `rd_en` from cycle 501, `done` never pulses, `pass`=0. A following `start` completes normally.
- `start` re-asserted at cycles 100 and 2000 during a run: ignored, exactly 256 reads. `start` and `abort` in the same IDLE cycle: stays IDLE.
- `RD_LAT`=2 with a 2-cycle RAM model: period 13 cycles, `done` at cycle 3329, `pass`=1. `rst_n` low at cycle 1000: all outputs 0 asynchronously.
